alu_op_issue: RTL

//  Issue-side partner of the ALU: decodes RV32I opcode/funct3/funct7[5] into the 4-bit ALU Operation.

---
 rtl/alu_op_pkg.sv | 43 ++++
 rtl/alu_op_decode.sv | 65 ++++++
 rtl/alu_op_issue.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Shared types for the ALU issue stage: the ALU Operation encoding, the RV32I
// major opcodes the stage decodes, and the post-decode bundle held in the
// main and skid registers.
package alu_op_pkg;

    localparam int ALU_DATA_W = 32;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRL    = 4'b0101,
        OP_SUB    = 4'b0110,
        OP_SRA    = 4'b0111,
        OP_SLT    = 4'b1000,
        OP_SLTU   = 4'b1001,
        OP_EQ     = 4'b1010,
        OP_NE     = 4'b1011,
        OP_LT     = 4'b1100,
        OP_GE     = 4'b1101,
        OP_GEU    = 4'b1110,
        OP_PASS_B = 4'b1111
    } alu_op_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Post-decode bundle; stored as-is in both the main and skid registers.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] SrcA;
        logic [ALU_DATA_W-1:0] SrcB;
        alu_op_t               op;
        logic                  illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I field decoder: opcode/funct3/funct7[5] -> ALU operation,
// illegal flag and immediate-operand select. Illegal encodings force PASS_B.
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output alu_op_t    o_op,
    output logic       o_illegal,
    output logic       o_use_imm
);

    // Decode the instruction class, then override the operation when illegal.
    always_comb begin
        o_op      = OP_PASS_B;
        o_illegal = 1'b0;
        o_use_imm = 1'b0;
        case (i_opcode)
            OPC_R, OPC_I_ALU: begin
                o_use_imm = (i_opcode == OPC_I_ALU);
                case (i_funct3)
                    3'b000: o_op = (i_funct7b5 && i_opcode == OPC_R) ? OP_SUB : OP_ADD;
                    3'b001: o_op = OP_SLL;
                    3'b010: o_op = OP_SLT;
                    3'b011: o_op = OP_SLTU;
                    3'b100: o_op = OP_XOR;
                    3'b101: o_op = i_funct7b5 ? OP_SRA : OP_SRL;
                    3'b110: o_op = OP_OR;
                    default: o_op = OP_AND;
                endcase
                // R: b5 only legal on ADD/SUB and SRL/SRA.
                // I: b5 is immediate data except on shifts; SLLI with b5 is illegal.
                if (i_opcode == OPC_R)
                    o_illegal = i_funct7b5 && (i_funct3 != 3'b000) && (i_funct3 != 3'b101);
                else
                    o_illegal = i_funct7b5 && (i_funct3 == 3'b001);
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                o_op      = OP_ADD;
                o_use_imm = 1'b1;
            end
            OPC_BRANCH: begin
                case (i_funct3)
                    3'b000: o_op = OP_EQ;
                    3'b001: o_op = OP_NE;
                    3'b100: o_op = OP_LT;
                    3'b101: o_op = OP_GE;
                    3'b110: o_op = OP_SLTU;
                    3'b111: o_op = OP_GEU;
                    default: o_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                o_op      = OP_PASS_B;
                o_use_imm = 1'b1;
            end
            // AUIPC, JAL and anything unknown: the PC path lives elsewhere.
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal)
            o_op = OP_PASS_B;
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes RV32I fields at capture, selects SrcA/SrcB and
// presents the bundle through a valid/ready register with a 1-entry skid
// (2 entries total). Full throughput, 1-cycle latency, in_ready registered.
// Optional: define ALU_ISSUE_STATS_EN to add stat_issued/stat_illegal counters.
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH    = ALU_DATA_W,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic                     in_funct7b5,
    input  logic [DATA_WIDTH-1:0]    in_rs1,
    input  logic [DATA_WIDTH-1:0]    in_rs2,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_illegal,
`endif
    output logic                     out_illegal
);

    alu_op_t       w_op;
    logic          w_illegal;
    logic          w_use_imm;
    issue_bundle_t w_new;
    logic          w_in_xfer;
    logic          w_out_xfer;

    issue_bundle_t r_main;
    issue_bundle_t r_skid;
    logic          r_main_v;
    logic          r_skid_v;

    alu_op_decode u_decode (
        .i_opcode   (in_opcode),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .o_op       (w_op),
        .o_illegal  (w_illegal),
        .o_use_imm  (w_use_imm)
    );

    // Build the post-decode bundle for the incoming fields.
    always_comb begin
        w_new.SrcA    = in_rs1;
        w_new.SrcB    = w_use_imm ? in_imm : in_rs2;
        w_new.op      = w_op;
        w_new.illegal = w_illegal;
    end

    assign in_ready   = !r_skid_v;
    assign w_in_xfer  = in_valid && !r_skid_v;
    assign w_out_xfer = r_main_v && out_ready;

    // Main/skid pair: EMPTY(0,0) -> ONE(1,0) -> FULL(1,1); skid refills main.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || w_out_xfer) begin
            // Main is free this cycle: skid has priority (no input in FULL).
            if (r_skid_v) begin
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_in_xfer) begin
                r_main   <= w_new;
                r_main_v <= 1'b1;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_in_xfer) begin
            // Main stalled: park the new bundle in the skid.
            r_skid   <= w_new;
            r_skid_v <= 1'b1;
        end
    end

    assign out_valid   = r_main_v;
    assign SrcA        = r_main.SrcA;
    assign SrcB        = r_main.SrcB;
    assign Operation   = r_main.op;
    assign out_illegal = r_main.illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_illegal;

    // Count output transfers; both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_issued  <= '0;
            r_stat_illegal <= '0;
        end else if (w_out_xfer) begin
            r_stat_issued <= r_stat_issued + 32'd1;
            if (r_main.illegal)
                r_stat_illegal <= r_stat_illegal + 32'd1;
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
